// File: rtl/regfile_pkg.sv
// Shared constants for the 16-entry register file and the pipeline control that addresses it.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 1 << ADDR_W;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/mux_16.sv
// 16:1 read-select multiplexer; one instance forms each register-file read port.
module mux_16
   import regfile_pkg::*;
(
   input  logic [DATA_W-1:0] din [NUM_REGS],
   input  logic [ADDR_W-1:0] sel,
   output logic [DATA_W-1:0] dout
);

   assign dout = din[sel];

endmodule

// File: rtl/register_32.sv
// Single register-file entry: a data register with write enable and synchronous active-high clear.
module register_32
   import regfile_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/regfile_16.sv
// 16x32 register file, one synchronous write port, two combinational read ports, r0 reads zero.
// Optional write-to-read forwarding on both read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_16
   import regfile_pkg::*;
(
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [DATA_W-1:0] data_writeReg,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [DATA_W-1:0] data_readRegA,
   output logic [DATA_W-1:0] data_readRegB
);

   logic [DATA_W-1:0]   entry [NUM_REGS];
   logic [NUM_REGS-1:1] we_dec;
   logic [DATA_W-1:0]   mux_a;
   logic [DATA_W-1:0]   mux_b;

   // r0 has neither a decode line nor a flop, so writes to it vanish.
   assign entry[0] = '0;

   always_comb begin
      we_dec = '0;
      for (int i = 1; i < NUM_REGS; i++)
         we_dec[i] = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(i));
   end

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      register_32 #(.W(DATA_W)) u_reg (
         .clock (clock),
         .reset (ctrl_reset),
         .en    (we_dec[g]),
         .d     (data_writeReg),
         .q     (entry[g])
      );
   end

   mux_16 u_mux_a (
      .din  (entry),
      .sel  (ctrl_readRegA),
      .dout (mux_a)
   );

   mux_16 u_mux_b (
      .din  (entry),
      .sel  (ctrl_readRegB),
      .dout (mux_b)
   );

`ifdef REGFILE_BYPASS_EN
   logic byp_a;
   logic byp_b;

   // Forward in-flight write data; never during reset and never for r0.
   assign byp_a = ctrl_writeEnable && !ctrl_reset && (ctrl_readRegA == ctrl_writeReg)
                  && (ctrl_readRegA != ZERO_REG);
   assign byp_b = ctrl_writeEnable && !ctrl_reset && (ctrl_readRegB == ctrl_writeReg)
                  && (ctrl_readRegB != ZERO_REG);

   assign data_readRegA = byp_a ? data_writeReg : mux_a;
   assign data_readRegB = byp_b ? data_writeReg : mux_b;
`else
   assign data_readRegA = mux_a;
   assign data_readRegB = mux_b;
`endif

endmodule

// File: doc/regfile_16.md
# regfile_16

Sixteen-entry, 32-bit register file with one synchronous write port and two combinational read ports. It sits directly upstream of the 16:1 read-select multiplexers (`mux_16`), which form its read ports, and feeds operands to the ALU/decode stage. Register 0 is hardwired to zero. An optional write-to-read bypass is available as a compile-time feature.

## Interface
- `DATA_W`, 32: register width.
- `NUM_REGS`, 16: entry count; fixed by the 4-bit address and the 16:1 read mux.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `ctrl_reset`  in  1  synchronous, active-high reset.
- `ctrl_writeEnable`  in  1  write strobe.
- `ctrl_writeReg`  in  4  write address.
- `data_writeReg`  in  32  write data.
- `ctrl_readRegA`  in  4  read port A address.
- `ctrl_readRegB`  in  4  read port B address.
- `data_readRegA`  out  32  read port A data.
- `data_readRegB`  out  32  read port B data.

## Operation
- **Storage:** entries r1..r15 are 32-bit registers. r0 is a constant 0 with no storage flop.
- **Write decode:** a one-hot 4:16 decoder of `ctrl_writeReg` is gated by `ctrl_writeEnable`. Bit 0 of the decode is forced low, so writes to r0 are silently dropped.
- **Reset:** while `ctrl_reset`=1 at a rising edge, every entry clears to 0. Reset has priority over a simultaneous write, and that write is lost.
- **Reads:** each port is one `mux_16` instance selecting among the 16 entry outputs by its address. Reads are purely combinational.
- **Port A and port B:** fully independent. Both may address the same entry, or r0, in the same cycle.
- **Arithmetic:** none; data passes through unmodified.

## Timing
- **Write latency:** data written at edge N is visible on the read ports after edge N (combinational settle). The write is not visible before edge N.
- **Same-cycle read/write, same address, no bypass:** the read returns the old value.
- **Reset:** is synchronous only, with no asynchronous clear. After the first rising edge with `ctrl_reset`=1, both read outputs are 0 for every address. Before that edge, contents are unknown (X in simulation).
- **Reset deasserted:** a write in the same cycle as deassertion (`ctrl_reset`=0 at the edge) takes effect normally.
- **Back-to-back writes:** consecutive writes to the same address are last-write-wins, one per cycle.
- **Write with `ctrl_writeEnable`=0:** no entry changes regardless of address or data.

## Configuration
- **Macro:** `REGFILE_BYPASS_EN`.
- **Defined:** each read port compares its address with `ctrl_writeReg`. When they match, `ctrl_writeEnable`=1, `ctrl_reset`=0, and the address is non-zero, the port returns `data_writeReg` in the same cycle (write-to-read forwarding). r0 always reads 0, and no bypass is applied during reset.
- **Undefined:** no forwarding; reads return stored contents only. The pipeline resolves same-cycle hazards through its own stall/forward logic.

## Structure
- **Shared package `regfile_pkg`:** holds `DATA_W`, `ADDR_W`(=4), `NUM_REGS`, and the `ZERO_REG` index constant (0). The pipeline control logic uses the same constants.
- **Sub-module `register_32`:**
  - One sub-module is natural: a 32-bit register with write enable and synchronous active-high reset.
  - Instantiate it 15 times in a generate loop for r1..r15.
- **Read ports:** two instances of `mux_16`, one per port. Input 0 is tied to 32'h0.
- **Bypass:** the optional bypass sits after each `mux_16` as a 2:1 select.

## Test plan
- **Reset then read all:** assert `ctrl_reset` one edge, then sweep both read addresses 0..15 -> every read is 32'h0.
- **Write/readback:**
  - Write r5=32'hDEADBEEF and r15=32'h12345678 on consecutive edges.
  - Read A=5, B=15 -> 32'hDEADBEEF and 32'h12345678.
  - r5's value is unchanged after the r15 write.
- **r0 immutability:** write r0=32'hFFFFFFFF with enable=1 -> reading r0 on both ports returns 0.
- **Enable and reset priority:**
  - Write r3=32'hA5A5A5A5 with enable=0 -> r3 keeps its prior value.
  - Write r3=32'h1 in the same edge as `ctrl_reset`=1 -> r3 reads 0.
- **Same-cycle hazard:**
  - Setup: r7=32'h11, then in one cycle write r7=32'h22 while reading A=B=7.
  - Without `REGFILE_BYPASS_EN`: reads 32'h11 before the edge and 32'h22 after it.
  - With `REGFILE_BYPASS_EN`: reads 32'h22 before the edge.
- **Random regression:** 10k random write/read cycles checked against a reference array model, with r0 forced to 0 and the bypass rule applied per the macro -> zero mismatches.
